// File: rtl/mem_access_pkg.sv
// Shared types and op-decode helpers for the MEM-stage load/store sequencer.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SB  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } memop_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } state_e;

    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
            default:              op_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_SB,
            OP_LBU, OP_LHU, OP_SH, OP_SW: op_is_legal = 1'b1;
            default:                      op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Sign/zero extension of raw little-endian load data according to MemOp.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_op,
    output logic [31:0] o_ext
);

    always_comb begin
        case (i_op)
            OP_LB:   o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
            OP_LBU:  o_ext = {24'b0, i_raw[7:0]};
            OP_LH:   o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
            OP_LHU:  o_ext = {16'b0, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: checks requests, splits misaligned
// accesses into byte accesses and returns results over valid/ready.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH       = 10,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        rsp_split,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      r_state;
    state_e      w_next;
    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_k;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic        r_split;

    logic [2:0]  w_size;
    logic [2:0]  w_rsize;
    logic [32:0] w_end;
    logic        w_oob;
    logic        w_misal;
    logic        w_bad_op;
    logic        w_fault;
    logic        w_last;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext_raw;
    logic [31:0] w_ext;

    assign w_size   = op_size(req_op);
    assign w_rsize  = op_size(r_op);
    // 33-bit end address so a request near 2^32 cannot wrap into range
    assign w_end    = {1'b0, req_addr} + {30'b0, w_size} - 33'd1;
    assign w_oob    = |(w_end >> ADDR_WIDTH);
    assign w_misal  = |(req_addr[1:0] & (w_size[1:0] - 2'd1));
    assign w_bad_op = !op_is_legal(req_op) || (req_we != op_is_store(req_op));
    assign w_fault  = w_bad_op || w_oob || (w_misal && !SPLIT_MISALIGNED);
    assign w_last   = ({1'b0, r_k} + 3'd1) == w_rsize;

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_k, 3'b000} +: 8] = mem_rdata[7:0];
    end

    assign w_ext_raw = (r_state == SPLIT) ? w_asm_next : mem_rdata;

    load_extend u_ext (
        .i_raw (w_ext_raw),
        .i_op  (r_op),
        .o_ext (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_fault)      w_next = RESP;
                    else if (w_misal) w_next = SPLIT;
                    else              w_next = ACCESS;
                end
            end
            ACCESS:  w_next = RESP;
            SPLIT:   if (w_last) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_op    = 3'b000;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        unique case (r_state)
            ACCESS: begin
                mem_read  = !r_we;
                mem_write = r_we;
                mem_op    = r_op;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            SPLIT: begin
                mem_read  = !r_we;
                mem_write = r_we;
                mem_op    = r_we ? OP_SB : OP_LBU;
                mem_addr  = r_addr + {30'b0, r_k};
                mem_wdata = {24'b0, r_wdata[{r_k, 3'b000} +: 8]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_op    <= 3'b000;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_k     <= 2'b0;
            r_asm   <= 32'b0;
            r_rdata <= 32'b0;
            r_fault <= 1'b0;
            r_split <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_k     <= 2'b0;
                        r_asm   <= 32'b0;
                        r_rdata <= 32'b0;
                        r_fault <= w_fault;
                        r_split <= w_misal && !w_fault;
                    end
                end
                ACCESS: begin
                    if (!r_we) r_rdata <= w_ext;
                end
                SPLIT: begin
                    r_k   <= r_k + 2'd1;
                    r_asm <= w_asm_next;
                    if (w_last && !r_we) r_rdata <= w_ext;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_fault = r_fault;
    assign rsp_split = r_split;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array DataMemory, directed table,
// corner sequences and random traffic against a reference model.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_fault, rsp_split;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_op;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_fault, b_rsp_split;
    logic [31:0] b_rsp_rdata;
    logic        b_mem_read, b_mem_write;
    logic [2:0]  b_mem_op;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata;
    assign b_mem_rdata = 32'h1234_5678;

    mem_access_ctrl #(.ADDR_WIDTH(10), .SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .rsp_split(rsp_split),
        .mem_read(mem_read), .mem_write(mem_write), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.ADDR_WIDTH(10), .SPLIT_MISALIGNED(1'b0)) u_nosplit (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_op(b_req_op), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
        .rsp_split(b_rsp_split),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_op(b_mem_op),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    logic [7:0] dmem [0:1023] = '{default: 8'h00};
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    function automatic int sz(input logic [2:0] op);
        case (op)
            3'b000, 3'b100, 3'b011: return 1;
            3'b001, 3'b101, 3'b110: return 2;
            default:                return 4;
        endcase
    endfunction

    // DataMemory: little-endian, zero-filled narrow reads, writes on the edge
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_read)
            for (int i = 0; i < sz(mem_op); i++)
                mem_rdata[8*i +: 8] = dmem[mem_addr[9:0] + 10'(i)];
    end

    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < sz(mem_op); i++)
                dmem[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];
    end

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    task automatic model(input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic flt,
                         output logic spl, output int lat);
        int s;
        bit st;
        longint last, v;
        s    = sz(op);
        st   = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
        last = longint'({32'b0, addr}) + s - 1;
        flt  = (we != st) || (last >= 1024);
        spl  = !flt && ((addr % s) != 0);
        rd   = 32'h0;
        if (!flt) begin
            if (we) begin
                for (int i = 0; i < s; i++)
                    ref_mem[int'(addr[9:0]) + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < s; i++)
                    v += longint'(ref_mem[int'(addr[9:0]) + i]) << (8*i);
                if ((op == 3'b000 || op == 3'b001) && v >= (64'd1 << (8*s-1)))
                    v -= (64'd1 << (8*s));
                rd = v[31:0];
            end
        end
        lat = flt ? 1 : (spl ? s + 1 : 2);
    endtask

    task automatic run(input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit pre, input int hold,
                       output logic [31:0] g_rd, output logic g_flt,
                       output logic g_spl, output int g_lat,
                       output int g_nrd, output int g_nwr);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_op = op;
        req_addr = addr; req_wdata = wdata; rsp_ready = pre;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g_lat = 1; g_nrd = 0; g_nwr = 0;
        wq_addr.delete(); wq_data.delete();
        while (!rsp_valid && g_lat < 12) begin
            if (mem_read) g_nrd++;
            if (mem_write) begin
                g_nwr++;
                wq_addr.push_back(mem_addr);
                wq_data.push_back(mem_wdata);
            end
            @(posedge clk); #1;
            g_lat++;
        end
        g_rd = rsp_rdata; g_flt = rsp_fault; g_spl = rsp_split;
        if (!rsp_valid) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected within 12");
        end
        if (!pre) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("hold_ctl", {26'b0, rsp_valid, req_ready, mem_read,
                    mem_write, rsp_fault, rsp_split},
                    {26'b0, 1'b1, 1'b0, 1'b0, 1'b0, g_flt, g_spl});
                chk("hold_rdata", rsp_rdata, g_rd);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_hs", {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic txn(input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit pre, input int hold);
        logic [31:0] e_rd, g_rd;
        logic e_flt, e_spl, g_flt, g_spl;
        int e_lat, g_lat, g_nrd, g_nwr, n;
        model(we, op, addr, wdata, e_rd, e_flt, e_spl, e_lat);
        run(we, op, addr, wdata, pre, hold, g_rd, g_flt, g_spl, g_lat,
            g_nrd, g_nwr);
        n = e_flt ? 0 : (e_spl ? sz(op) : 1);
        chk("rnd_rdata", g_rd, e_rd);
        chk("rnd_flags", {30'b0, g_flt, g_spl}, {30'b0, e_flt, e_spl});
        chk("rnd_lat", g_lat, e_lat);
        chk("rnd_pulses", {g_nrd[15:0], g_nwr[15:0]},
            {16'(we ? 0 : n), 16'(we ? n : 0)});
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        flt;
        logic        spl;
        int          lat;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [31:0] g_rd, m_rd;
        logic g_flt, g_spl, m_flt, m_spl;
        int g_lat, g_nrd, g_nwr, m_lat, n;
        logic [7:0] old_b [3];

        vt[0]  = '{1'b1, 3'b111, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2};
        vt[1]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 2};
        vt[2]  = '{1'b1, 3'b011, 32'h201, 32'h000000FE, 32'h0, 1'b0, 1'b0, 2};
        vt[3]  = '{1'b1, 3'b011, 32'h202, 32'h00000080, 32'h0, 1'b0, 1'b0, 2};
        vt[4]  = '{1'b0, 3'b001, 32'h201, 32'h0, 32'hFFFF80FE, 1'b0, 1'b1, 3};
        vt[5]  = '{1'b0, 3'b101, 32'h201, 32'h0, 32'h000080FE, 1'b0, 1'b1, 3};
        vt[6]  = '{1'b1, 3'b111, 32'h103, 32'h11223344, 32'h0, 1'b0, 1'b1, 5};
        vt[7]  = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h00112233, 1'b0, 1'b0, 2};
        vt[8]  = '{1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1'b1, 1'b0, 1};
        vt[9]  = '{1'b1, 3'b010, 32'h010, 32'h5, 32'h0, 1'b1, 1'b0, 1};
        vt[10] = '{1'b0, 3'b111, 32'h010, 32'h0, 32'h0, 1'b1, 1'b0, 1};
        vt[11] = '{1'b0, 3'b000, 32'h201, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 2};
        vt[12] = '{1'b0, 3'b100, 32'h202, 32'h0, 32'h00000080, 1'b0, 1'b0, 2};
        vt[13] = '{1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1};
        vt[14] = '{1'b1, 3'b110, 32'h3FF, 32'hBEEF, 32'h0, 1'b1, 1'b0, 1};
        vt[15] = '{1'b1, 3'b111, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2};
        vt[16] = '{1'b0, 3'b001, 32'h3FE, 32'h0, 32'hFFFFCAFE, 1'b0, 1'b0, 2};
        vt[17] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h3344ADBE, 1'b0, 1'b1, 5};

        req_valid = 0; req_we = 0; req_op = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_op = 0; b_req_addr = 0;
        b_req_wdata = 0; b_rsp_ready = 0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctl", {29'b0, req_ready, rsp_valid, rsp_fault | rsp_split},
            32'h4);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_mem", {31'b0, |{mem_read, mem_write, mem_op, mem_addr,
            mem_wdata}}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            model(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata,
                  m_rd, m_flt, m_spl, m_lat);
            run(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, 1'b0, 0,
                g_rd, g_flt, g_spl, g_lat, g_nrd, g_nwr);
            n = vt[i].flt ? 0 : (vt[i].spl ? sz(vt[i].op) : 1);
            chk($sformatf("vec%0d_rdata", i), g_rd, vt[i].rd);
            chk($sformatf("vec%0d_flags", i), {30'b0, g_flt, g_spl},
                {30'b0, vt[i].flt, vt[i].spl});
            chk($sformatf("vec%0d_lat", i), g_lat, vt[i].lat);
            chk($sformatf("vec%0d_pulses", i), {g_nrd[15:0], g_nwr[15:0]},
                {16'(vt[i].we ? 0 : n), 16'(vt[i].we ? n : 0)});
            if (vt[i].we && vt[i].spl) begin
                for (int k = 0; k < n; k++) begin
                    chk($sformatf("vec%0d_sb_addr%0d", i, k),
                        (k < wq_addr.size()) ? wq_addr[k] : 32'hX,
                        vt[i].addr + 32'(k));
                    chk($sformatf("vec%0d_sb_data%0d", i, k),
                        (k < wq_data.size()) ? wq_data[k] : 32'hX,
                        {24'b0, vt[i].wdata[8*k +: 8]});
                end
            end
        end

        // backpressure on a completed load
        txn(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 5);

        // reset in the middle of a split store
        for (int j = 0; j < 3; j++) old_b[j] = ref_mem[16'h102 + j];
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b111;
        req_addr = 32'h101; req_wdata = 32'hA1B2C3D4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_k0", {31'b0, mem_write}, 32'd1);
        @(posedge clk); #1;
        chk("rst_mid_k1_addr", mem_addr, 32'h102);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", {30'b0, mem_write, mem_read}, 32'd0);
        chk("rst_mid_idle", {30'b0, req_ready, rsp_valid}, 32'h2);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ref_mem[16'h101] = 8'hD4;
        chk("rst_mid_b101", {24'b0, dmem[16'h101]}, 32'hD4);
        for (int j = 0; j < 3; j++)
            chk($sformatf("rst_mid_b%0h", 16'h102 + j),
                {24'b0, dmem[16'h102 + j]}, {24'b0, old_b[j]});

        // non-splitting instance: misaligned is a fault, aligned passes
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_op = 3'b001;
        b_req_addr = 32'h001;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("ns_fault", {28'b0, b_rsp_valid, b_rsp_fault, b_rsp_split,
            b_mem_read | b_mem_write}, 32'hC);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
        chk("ns_idle", {31'b0, b_req_ready}, 32'd1);
        b_req_valid = 1'b1; b_req_op = 3'b010; b_req_addr = 32'h004;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("ns_access", {30'b0, b_mem_read, b_rsp_valid}, 32'h2);
        @(posedge clk); #1;
        chk("ns_rdata", b_rsp_rdata, 32'h12345678);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;

        for (int r = 0; r < 300; r++) begin
            logic [2:0]  op;
            logic        we;
            logic [31:0] a;
            op = 3'($urandom_range(0, 7));
            we = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
            if ($urandom_range(0, 9) == 0) we = ~we;
            a = ($urandom_range(0, 9) == 0) ? $urandom
                                            : 32'($urandom_range(0, 1023));
            txn(we, op, a, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2));
        end

        n = 0;
        for (int j = 0; j < 1024; j++)
            if (dmem[j] !== ref_mem[j]) n++;
        chk("final_mem_bytes_differing", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
